clock_gate_ctrl: RTL and testbench
==================================

# clock_gate_ctrl

Per-domain clock-gate controller, directly upstream of the gating cell and `clock_gate_checker`. It runs on the free-running source clock of one domain and produces two outputs:
- `clk_en`, which drives the AND/ICG gating cell.
- `gate_expect`, which feeds the checker's `clk_gate[<domain>]` expectation.

It auto-gates after a programmable idle period, honours force requests, enforces a minimum off-time and sequences the enable/expectation edges so the checker never sees a gated-clock edge while expectation is set.

## Interface
Parameters:
- `CNT_W`, 8, width of idle threshold and idle counter
- `MIN_OFF`, 4, minimum cycles spent in GATED (≥1)
- `STAT_W`, 16, width of gating-event counter

Ports:
- `clk`  in  1  free-running (ungated) domain source clock
- `rst_n`  in  1  reset, synchronous, active-low
- `busy`  in  1  domain activity; 1 blocks idle gating and wakes a gated domain
- `wake_req`  in  1  explicit wake request (pulse or level)
- `force_gate`  in  1  gate now, ignoring idle threshold and `busy`
- `force_on`  in  1  hold clock running; highest priority
- `idle_thresh`  in  CNT_W  consecutive idle cycles before auto-gate; 0 disables auto-gate
- `clk_en`  out  1  registered gate enable
- `gate_expect`  out  1  registered checker expectation
- `gated`  out  1  status: state is GATED
- `gate_events`  out  STAT_W  saturating count of RUN→ENTER transitions

## Operation
States (registered, one-hot or encoded): RUN, ENTER, GATED, EXIT.
- RUN: `clk_en`=1, `gate_expect`=0. `idle_cnt` increments on each cycle with `busy`=0 & `force_on`=0; it clears to 0 when either `busy` or `force_on` is 1.
  - →ENTER if `force_on`=0 and either `force_gate`=1, or (`idle_thresh`≠0, `busy`=0, and `idle_cnt`+1 ≥ `idle_thresh`).
- ENTER: `clk_en`=0, `gate_expect`=0. Lasts exactly 1 cycle, then →GATED.
- GATED: `clk_en`=0, `gate_expect`=1, `off_cnt` increments (saturates at MIN_OFF).
  - →EXIT when `wake_pend` is set and `off_cnt` ≥ MIN_OFF−1.
- EXIT: `clk_en`=0, `gate_expect`=0. Lasts 1 cycle, then →RUN and clears `idle_cnt`.
- `wake_pend`: set when any of `busy`, `wake_req` or `force_gate`=0-with-`force_on`=1 is sampled in ENTER or GATED. Cleared on entry to RUN.
  - `force_gate`=1 suppresses the `busy` and `wake_req` wake sources; `force_on` still wakes.
- `gate_events` increments on each RUN→ENTER transition and saturates at all-ones.
- `idle_thresh` may change at any time. The comparison uses the current value with ≥, so lowering it below `idle_cnt` gates on the next idle cycle.

## Timing
- Reset (`rst_n`=0 sampled at an edge): state=RUN, `clk_en`=1, `gate_expect`=0, `gated`=0, all counters 0. Reset applied mid-GATED sets `clk_en`=1 and `gate_expect`=0 at the same edge.
- Idle gating latency: with threshold N, `busy`=0 sampled at N consecutive edges. `clk_en` falls after the Nth edge; `gate_expect` rises one edge later.
- Wake latency, from first wake sample with min-off satisfied: `gate_expect` falls after that edge; `clk_en` rises one edge later.
- Invariant: `clk_en`=1 and `gate_expect`=1 are never both asserted in any cycle.
- Minimum `clk_en`-low time is MIN_OFF+2 cycles.
- Simultaneous `busy`=1 and threshold reached in RUN: `busy` wins and the block stays in RUN.
- `force_on` together with `force_gate`: the block stays in RUN.

## Structure
- Package `clock_gate_pkg`:
  - `cg_state_e` (RUN, ENTER, GATED, EXIT).
  - `clk_e` domain enum, shared with the checker bench.
- Sub-module `clock_gate_idle_counter`: the idle counter with threshold compare, outputting `idle_hit`.
- One `clock_gate_ctrl` instance per domain. The top connects `clk_en` to the gating cell and `gate_expect` to `u_clk_chkr.clk_gate[<domain>]`.

## Test plan
- Reset then idle: `idle_thresh`=3, `busy`=0 from reset release. Required: `clk_en`=0 after edge 3, `gate_expect`=1 after edge 4, `gate_events`=1, and the checker passes.
- Wake: from GATED after 10 cycles, 1-cycle `wake_req` pulse. Required: `gate_expect`=0 at the next edge, `clk_en`=1 one edge later, and no checker error.
- Min off-time: `MIN_OFF`=4, `wake_req` pulsed in the ENTER cycle. Required: the pulse is latched, GATED lasts exactly 4 cycles, then EXIT→RUN.
- Force priority, in two steps:
  - `force_gate`=1 with `busy`=1 → RUN→ENTER on the next edge.
  - Assert `force_on`=1 in GATED → EXIT, then RUN, and the block stays in RUN while both forces are held.
- Threshold 0 / busy: `idle_thresh`=0 and `busy`=0 for 1000 cycles → `clk_en` stays 1. Then set `idle_thresh`=5 with `busy` toggling every 4 cycles → never gates.
- Reset mid-GATED: drive `rst_n`=0 for one edge. Required: `clk_en`=1, `gate_expect`=0, `gate_events`=0 after that edge. Saturation check: force 2^STAT_W+1 gate events → count holds at all-ones.

Source files
------------

// File: rtl/clock_gate_pkg.sv
// Shared types for the per-domain clock-gate controller and its checker bench.
package clock_gate_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ENTER = 2'd1,
        GATED = 2'd2,
        EXIT  = 2'd3
    } cg_state_e;

    // Clock domains; the index selects the checker's clk_gate[] bit.
    typedef enum logic [1:0] {
        CLK_CORE   = 2'd0,
        CLK_BUS    = 2'd1,
        CLK_PERIPH = 2'd2,
        CLK_IO     = 2'd3
    } clk_e;

endpackage

// File: rtl/clock_gate_idle_counter.sv
// Counts consecutive idle RUN cycles and flags when the programmable threshold is reached.
module clock_gate_idle_counter
    import clock_gate_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             busy,
    input  logic             force_on,
    input  logic [CNT_W-1:0] idle_thresh,
    output logic             idle_hit
);

    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W:0]   cnt_next;

    // One bit wider so a saturated counter still compares correctly against any threshold.
    assign cnt_next = {1'b0, idle_cnt} + (CNT_W+1)'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!run || busy || force_on) begin
            idle_cnt <= '0;
        end else if (!(&idle_cnt)) begin
            idle_cnt <= cnt_next[CNT_W-1:0];
        end
    end

    assign idle_hit = (idle_thresh != '0) && !busy && (cnt_next >= {1'b0, idle_thresh});

endmodule

// File: rtl/clock_gate_ctrl.sv
// Per-domain clock-gate controller: idle auto-gating, force requests, minimum off-time
// and break-before-make sequencing of clk_en versus the checker expectation.
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int MIN_OFF = 4,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              busy,
    input  logic              wake_req,
    input  logic              force_gate,
    input  logic              force_on,
    input  logic [CNT_W-1:0]  idle_thresh,
    output logic              clk_en,
    output logic              gate_expect,
    output logic              gated,
    output logic [STAT_W-1:0] gate_events
);

    localparam int OFF_W = $clog2(MIN_OFF + 1);

    cg_state_e        state;
    cg_state_e        next_state;
    logic [OFF_W-1:0] off_cnt;
    logic             wake_pend;
    logic             wake_pend_next;
    logic             wake_src;
    logic             off_done;
    logic             idle_hit;
    logic             gate_start;

    clock_gate_idle_counter #(
        .CNT_W(CNT_W)
    ) u_idle_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state == RUN),
        .busy       (busy),
        .force_on   (force_on),
        .idle_thresh(idle_thresh),
        .idle_hit   (idle_hit)
    );

    // force_gate masks activity-driven wakes; force_on always wakes.
    assign wake_src = force_on || (!force_gate && (busy || wake_req));
    assign off_done = off_cnt >= OFF_W'(MIN_OFF - 1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state     = state;
        wake_pend_next = 1'b0;
        gate_start     = 1'b0;
        unique case (state)
            RUN: begin
                if (!force_on && (force_gate || idle_hit)) begin
                    next_state = ENTER;
                    gate_start = 1'b1;
                end
            end
            ENTER: begin
                wake_pend_next = wake_pend || wake_src;
                next_state     = GATED;
            end
            GATED: begin
                wake_pend_next = wake_pend || wake_src;
                if ((wake_pend || wake_src) && off_done) begin
                    next_state = EXIT;
                end
            end
            EXIT: begin
                next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            off_cnt     <= '0;
            wake_pend   <= 1'b0;
            gate_events <= '0;
            clk_en      <= 1'b1;
            gate_expect <= 1'b0;
            gated       <= 1'b0;
        end else begin
            state       <= next_state;
            wake_pend   <= wake_pend_next;
            clk_en      <= (next_state == RUN);
            gate_expect <= (next_state == GATED);
            gated       <= (next_state == GATED);
            if (state != GATED) begin
                off_cnt <= '0;
            end else if (off_cnt != OFF_W'(MIN_OFF)) begin
                off_cnt <= off_cnt + OFF_W'(1);
            end
            if (gate_start && !(&gate_events)) begin
                gate_events <= gate_events + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Scoreboard bench for clock_gate_ctrl: stimulus pushes model predictions, a monitor
// compares them one cycle at a time against the DUT outputs.
module tb_clock_gate_ctrl;

    localparam int CNT_W   = 8;
    localparam int MIN_OFF = 4;
    localparam int STAT_W  = 6;
    localparam int EV_MAX  = (1 << STAT_W) - 1;
    localparam int IDLE_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit clk_en;
        bit gate_expect;
        bit gated;
        int events;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              busy;
    logic              wake_req;
    logic              force_gate;
    logic              force_on;
    logic [CNT_W-1:0]  idle_thresh;
    logic              clk_en;
    logic              gate_expect;
    logic              gated;
    logic [STAT_W-1:0] gate_events;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    clock_gate_ctrl #(
        .CNT_W  (CNT_W),
        .MIN_OFF(MIN_OFF),
        .STAT_W (STAT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .busy       (busy),
        .wake_req   (wake_req),
        .force_gate (force_gate),
        .force_on   (force_on),
        .idle_thresh(idle_thresh),
        .clk_en     (clk_en),
        .gate_expect(gate_expect),
        .gated      (gated),
        .gate_events(gate_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a timeline of the off period rather than a state register.
    // running: clock enabled; off_age: edges since the gate decision (1 = first low cycle);
    // leaving: the final low cycle before the clock returns.
    bit m_running = 1'b1;
    bit m_leaving = 1'b0;
    int m_off_age = 0;
    int m_idle    = 0;
    bit m_wake    = 1'b0;
    int m_events  = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit b, input bit w, input bit fg,
                              input bit fo, input int thr);
        bit hit;
        bit src;
        if (!r) begin
            m_running = 1'b1; m_leaving = 1'b0; m_off_age = 0;
            m_idle = 0; m_wake = 1'b0; m_events = 0;
        end else if (m_running) begin
            hit = (thr != 0) && !b && (m_idle + 1 >= thr);
            if (b || fo) m_idle = 0;
            else if (m_idle < IDLE_MAX) m_idle++;
            if (!fo && (fg || hit)) begin
                m_running = 1'b0;
                m_off_age = 1;
                m_idle    = 0;
                m_wake    = 1'b0;
                if (m_events < EV_MAX) m_events++;
            end
        end else if (m_leaving) begin
            m_running = 1'b1; m_leaving = 1'b0; m_off_age = 0;
            m_idle = 0; m_wake = 1'b0;
        end else begin
            src = fo || (!fg && (b || w));
            // Leaving requires at least MIN_OFF gated cycles, counting the current one.
            if (m_off_age >= 2 && (m_wake || src) && (m_off_age - 1) >= MIN_OFF) begin
                m_leaving = 1'b1;
            end else begin
                m_wake = m_wake || src;
                m_off_age++;
            end
        end
    endtask

    task automatic step(input bit r, input bit b, input bit w, input bit fg,
                        input bit fo, input int thr);
        exp_t e;
        @(negedge clk);
        rst_n       = r;
        busy        = b;
        wake_req    = w;
        force_gate  = fg;
        force_on    = fo;
        idle_thresh = CNT_W'(thr);
        model_edge(r, b, w, fg, fo, thr);
        e.clk_en      = m_running;
        e.gate_expect = !m_running && !m_leaving && (m_off_age >= 2);
        e.gated       = e.gate_expect;
        e.events      = m_events;
        exp_q.push_back(e);
    endtask

    // Monitor: one prediction per edge, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("clk_en", int'(clk_en), int'(e.clk_en));
            check("gate_expect", int'(gate_expect), int'(e.gate_expect));
            check("gated", int'(gated), int'(e.gated));
            check("gate_events", int'(gate_events), e.events);
            check("en_expect_exclusive", int'(clk_en && gate_expect), 0);
        end
    end

    initial begin
        rst_n = 1'b0; busy = 1'b0; wake_req = 1'b0;
        force_gate = 1'b0; force_on = 1'b0; idle_thresh = '0;

        // Reset, then idle gating with threshold 3.
        repeat (2) step(0, 0, 0, 0, 0, 3);
        repeat (12) step(1, 0, 0, 0, 0, 3);
        // Single-cycle wake pulse after a long gated stretch.
        step(1, 0, 1, 0, 0, 3);
        repeat (4) step(1, 0, 0, 0, 0, 0);

        // Min off-time: wake pulsed during the ENTER cycle.
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        repeat (8) step(1, 0, 0, 0, 0, 0);

        // force_gate beats busy; then force_on wakes and holds against force_gate.
        step(1, 1, 0, 1, 0, 0);
        repeat (6) step(1, 0, 0, 0, 0, 0);
        repeat (12) step(1, 0, 0, 1, 1, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);

        // Threshold 0 never gates; threshold 5 with busy toggling every 4 cycles never gates.
        repeat (1000) step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++) step(1, ((i / 4) % 2) == 0, 0, 0, 0, 5);

        // Reset applied in the middle of GATED.
        step(1, 0, 0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);

        // Saturate the event counter: 2^STAT_W+2 forced gate/wake rounds.
        for (int n = 0; n < EV_MAX + 3; n++) begin
            step(1, 0, 0, 1, 0, 0);
            repeat (7) step(1, 0, 1, 0, 0, 0);
        end

        // Randomized traffic with changing thresholds and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 399) != 0),
                 ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 39) == 0),
                 int'($urandom_range(0, 8)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
